uart_mmio_bridge: RTL and testbench

Serial front end for the Hack computer's UART MMIO window. Sits between the board UART pins and the computer's `mmio_uart_*` ports. Deserialises 8N1 RX frames into bytes presented on `mmio_uart_data_in` with `mmio_uart_doorbell_flag`, and serialises bytes taken from `mmio_uart_data_out` onto the TX pin. The memory decoder supplies single-cycle `rx_ack`/`tx_req` strobes when software touches the UART registers.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_mmio_bridge_if.sv | 23 ++
 rtl/uart_rx_fifo.sv | 80 ++++++++
 rtl/uart_mmio_bridge.sv | 225 ++++++++++++++++++++++
 tb/tb_uart_mmio_bridge.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART MMIO bridge: FSM state enums,
// the data-width constant and the bit-period counter width helper.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  // The bit-period counter only ever holds 0..div-1.
  function automatic int div_width(input int div);
    return (div < 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/uart_mmio_bridge_if.sv
// MMIO-side handshake between the Hack computer (master) and the UART
// bridge (slave): RX head/doorbell/ack, TX data/request and busy status.
interface uart_mmio_bridge_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] mmio_uart_data_in;
  logic                 mmio_uart_doorbell_flag;
  logic                 mmio_uart_rx_ack;
  logic [DATA_BITS-1:0] mmio_uart_data_out;
  logic                 mmio_uart_tx_req;
  logic                 tx_busy;

  modport master (
    input  mmio_uart_data_in, mmio_uart_doorbell_flag, tx_busy,
    output mmio_uart_rx_ack, mmio_uart_data_out, mmio_uart_tx_req
  );

  modport slave (
    output mmio_uart_data_in, mmio_uart_doorbell_flag, tx_busy,
    input  mmio_uart_rx_ack, mmio_uart_data_out, mmio_uart_tx_req
  );

endinterface

// File: rtl/uart_rx_fifo.sv
// RX byte FIFO: synchronous push/pop with a registered head that already
// shows the next entry on the edge after a pop (0 when empty).
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);

  if ((DEPTH < 2) || ((1 << AW) != DEPTH)) begin : g_depth_chk
    $error("uart_rx_fifo: DEPTH must be a power of two >= 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [AW-1:0]    rd_ptr_next;
  logic [AW:0]      count_reg;
  logic [WIDTH-1:0] head_reg, head_next;
  logic             wr_en, rd_en;

  assign full  = (count_reg == DEPTH_C);
  assign empty = (count_reg == '0);
  assign head  = head_reg;

  // A pop at full frees the slot the push lands in.
  assign wr_en       = push && (!full || pop);
  assign rd_en       = pop && !empty;
  assign rd_ptr_next = rd_ptr_reg + 1'b1;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Look one entry ahead so the head is valid immediately after a pop;
  // bypass the write when the pushed byte becomes the new head.
  always_comb begin
    head_next = head_reg;
    if (rd_en) begin
      if (count_reg == ONE_C) begin
        head_next = wr_en ? push_data : '0;
      end else begin
        head_next = mem[rd_ptr_next];
      end
    end else if (wr_en && empty) begin
      head_next = push_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= '0;
    end else begin
      head_reg <= head_next;
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_en) rd_ptr_reg <= rd_ptr_next;
      case ({wr_en, rd_en})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/uart_mmio_bridge.sv
// 8N1 UART front end for the Hack MMIO window. RX storage is a FIFO when
// UART_MMIO_BRIDGE_RX_FIFO_EN is defined, otherwise a single holding register.
module uart_mmio_bridge
  import uart_pkg::*;
#(
  parameter int CLK_HZ   = 27_000_000,
  parameter int BAUD     = 115200,
  parameter int RX_DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     uart_rx,
  output logic                     uart_tx,
  uart_mmio_bridge_if.slave        mmio,
  output logic                     rx_overrun,
  output logic                     rx_frame_err
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = div_width(DIV);
  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

  if (DIV < 4) begin : g_div_chk
    $error("uart_mmio_bridge: CLK_HZ / BAUD must be >= 4");
  end
  if (RX_DEPTH < 2) begin : g_rx_depth_chk
    $error("uart_mmio_bridge: RX_DEPTH must be >= 2");
  end

  // ---------------- RX deserialiser ----------------
  rx_state_t            rx_state_reg;
  logic [CW-1:0]        rx_cnt_reg;
  logic [2:0]           rx_bit_reg;
  logic [DATA_BITS-1:0] rx_shift_reg;
  logic                 rx_s1_reg, rx_s2_reg, rx_prev_reg;
  logic                 rx_push_reg;
  logic                 rx_frame_err_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // Synchroniser resets to the idle level so release cannot fake an edge.
      rx_s1_reg        <= 1'b1;
      rx_s2_reg        <= 1'b1;
      rx_prev_reg      <= 1'b1;
      rx_state_reg     <= RX_IDLE;
      rx_cnt_reg       <= '0;
      rx_bit_reg       <= '0;
      rx_shift_reg     <= '0;
      rx_push_reg      <= 1'b0;
      rx_frame_err_reg <= 1'b0;
    end else begin
      rx_s1_reg   <= uart_rx;
      rx_s2_reg   <= rx_s1_reg;
      rx_prev_reg <= rx_s2_reg;
      rx_push_reg <= 1'b0;
      case (rx_state_reg)
        RX_IDLE: begin
          if (rx_prev_reg && !rx_s2_reg) begin
            rx_state_reg <= RX_START;
            rx_cnt_reg   <= '0;
          end
        end
        RX_START: begin
          if (rx_cnt_reg == HALF_M1) begin
            rx_cnt_reg   <= '0;
            rx_bit_reg   <= '0;
            rx_state_reg <= rx_s2_reg ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_reg <= rx_cnt_reg + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt_reg == DIV_M1) begin
            rx_cnt_reg   <= '0;
            rx_shift_reg <= {rx_s2_reg, rx_shift_reg[DATA_BITS-1:1]};
            rx_bit_reg   <= rx_bit_reg + 1'b1;
            if (rx_bit_reg == LAST_BIT) rx_state_reg <= RX_STOP;
          end else begin
            rx_cnt_reg <= rx_cnt_reg + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt_reg == DIV_M1) begin
            rx_cnt_reg   <= '0;
            rx_state_reg <= RX_IDLE;
            if (rx_s2_reg) rx_push_reg      <= 1'b1;
            else           rx_frame_err_reg <= 1'b1;
          end else begin
            rx_cnt_reg <= rx_cnt_reg + 1'b1;
          end
        end
        default: rx_state_reg <= RX_IDLE;
      endcase
    end
  end

  // ---------------- RX storage ----------------
  logic                 rx_full, rx_empty, rx_pop;
  logic [DATA_BITS-1:0] rx_head;
  logic                 rx_overrun_reg;

  assign rx_pop = mmio.mmio_uart_rx_ack && !rx_empty;

`ifdef UART_MMIO_BRIDGE_RX_FIFO_EN
  uart_rx_fifo #(
    .DEPTH (RX_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_rx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rx_push_reg),
    .push_data (rx_shift_reg),
    .pop       (rx_pop),
    .full      (rx_full),
    .empty     (rx_empty),
    .head      (rx_head)
  );
`else
  logic                 hold_valid_reg;
  logic [DATA_BITS-1:0] hold_data_reg;

  assign rx_full  = hold_valid_reg;
  assign rx_empty = !hold_valid_reg;
  assign rx_head  = hold_data_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_valid_reg <= 1'b0;
      hold_data_reg  <= '0;
    end else if (rx_push_reg && (!hold_valid_reg || rx_pop)) begin
      hold_valid_reg <= 1'b1;
      hold_data_reg  <= rx_shift_reg;
    end else if (rx_pop) begin
      hold_valid_reg <= 1'b0;
      hold_data_reg  <= '0;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_overrun_reg <= 1'b0;
    end else if (rx_push_reg && rx_full && !rx_pop) begin
      rx_overrun_reg <= 1'b1;
    end
  end

  assign mmio.mmio_uart_data_in       = rx_head;
  assign mmio.mmio_uart_doorbell_flag = !rx_empty;
  assign rx_overrun                   = rx_overrun_reg;
  assign rx_frame_err                 = rx_frame_err_reg;

  // ---------------- TX serialiser ----------------
  tx_state_t            tx_state_reg;
  logic [CW-1:0]        tx_cnt_reg;
  logic [2:0]           tx_bit_reg;
  logic [DATA_BITS-1:0] tx_shift_reg;
  logic                 tx_line_reg;
  logic                 tx_busy_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state_reg <= TX_IDLE;
      tx_cnt_reg   <= '0;
      tx_bit_reg   <= '0;
      tx_shift_reg <= '0;
      tx_line_reg  <= 1'b1;
      tx_busy_reg  <= 1'b0;
    end else begin
      case (tx_state_reg)
        TX_IDLE: begin
          if (mmio.mmio_uart_tx_req) begin
            tx_shift_reg <= mmio.mmio_uart_data_out;
            tx_line_reg  <= 1'b0;
            tx_busy_reg  <= 1'b1;
            tx_cnt_reg   <= '0;
            tx_state_reg <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt_reg == DIV_M1) begin
            tx_cnt_reg   <= '0;
            tx_bit_reg   <= '0;
            tx_line_reg  <= tx_shift_reg[0];
            tx_shift_reg <= {1'b0, tx_shift_reg[DATA_BITS-1:1]};
            tx_state_reg <= TX_DATA;
          end else begin
            tx_cnt_reg <= tx_cnt_reg + 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_cnt_reg == DIV_M1) begin
            tx_cnt_reg <= '0;
            if (tx_bit_reg == LAST_BIT) begin
              tx_line_reg  <= 1'b1;
              tx_state_reg <= TX_STOP;
            end else begin
              tx_line_reg  <= tx_shift_reg[0];
              tx_shift_reg <= {1'b0, tx_shift_reg[DATA_BITS-1:1]};
              tx_bit_reg   <= tx_bit_reg + 1'b1;
            end
          end else begin
            tx_cnt_reg <= tx_cnt_reg + 1'b1;
          end
        end
        TX_STOP: begin
          if (tx_cnt_reg == DIV_M1) begin
            tx_cnt_reg   <= '0;
            tx_busy_reg  <= 1'b0;
            tx_state_reg <= TX_IDLE;
          end else begin
            tx_cnt_reg <= tx_cnt_reg + 1'b1;
          end
        end
        default: tx_state_reg <= TX_IDLE;
      endcase
    end
  end

  assign uart_tx      = tx_line_reg;
  assign mmio.tx_busy = tx_busy_reg;

endmodule

// File: tb/tb_uart_mmio_bridge.sv
// Scoreboard bench for uart_mmio_bridge at DIV = 10: stimulus queues expected
// bytes, RX/TX monitors pop and compare when the DUT presents data.
`timescale 1ns/1ps
module tb_uart_mmio_bridge;

  localparam int DIV = 10;

  logic clk = 1'b0;
  logic reset;
  logic uart_rx;
  logic uart_tx;
  logic rx_overrun, rx_frame_err;

  uart_mmio_bridge_if mmio();

  uart_mmio_bridge #(
    .CLK_HZ   (1_000_000),
    .BAUD     (100_000),
    .RX_DEPTH (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .uart_rx      (uart_rx),
    .uart_tx      (uart_tx),
    .mmio         (mmio),
    .rx_overrun   (rx_overrun),
    .rx_frame_err (rx_frame_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] rx_exp[$];
  logic [7:0] tx_exp[$];
  logic tx_mon_en = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    tick(DIV);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      tick(DIV);
    end
    uart_rx = stop_bit;
    tick(DIV);
    uart_rx = 1'b1;
    tick(2 * DIV);
  endtask

  task automatic start_tx(input logic [7:0] b);
    mmio.mmio_uart_data_out = b;
    mmio.mmio_uart_tx_req   = 1'b1;
    tick(1);
    mmio.mmio_uart_tx_req   = 1'b0;
  endtask

  task automatic measure_busy(output int n);
    n = 0;
    while (mmio.tx_busy && n < 300) begin
      n++;
      tick(1);
    end
  endtask

  task automatic ack();
    mmio.mmio_uart_rx_ack = 1'b1;
    tick(1);
    mmio.mmio_uart_rx_ack = 1'b0;
  endtask

  task automatic wait_doorbell();
    int n = 0;
    while (!mmio.mmio_uart_doorbell_flag && n < 400) begin
      n++;
      tick(1);
    end
    check("doorbell_wait", mmio.mmio_uart_doorbell_flag, 1);
  endtask

  // RX monitor: an ack with the doorbell up presents a byte to the scoreboard.
  always @(negedge clk) begin
    if (!reset && mmio.mmio_uart_rx_ack && mmio.mmio_uart_doorbell_flag) begin
      if (rx_exp.size() == 0) begin
        check("rx_unexpected", 32'(mmio.mmio_uart_data_in), 32'hFFFF_FFFF);
      end else begin
        check("rx_byte", 32'(mmio.mmio_uart_data_in), 32'(rx_exp.pop_front()));
      end
    end
  end

  // TX monitor: decode each frame mid-bit and compare with the queued byte.
  initial begin
    logic [7:0] got;
    forever begin
      @(negedge uart_tx);
      if (tx_mon_en && !reset) begin
        got = '0;
        repeat (DIV / 2) @(negedge clk);
        check("tx_start_bit", uart_tx, 0);
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          got[i] = uart_tx;
        end
        repeat (DIV) @(negedge clk);
        check("tx_stop_bit", uart_tx, 1);
        if (tx_exp.size() == 0) begin
          check("tx_unexpected", 32'(got), 32'hFFFF_FFFF);
        end else begin
          check("tx_byte", 32'(got), 32'(tx_exp.pop_front()));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    reset                   = 1'b1;
    uart_rx                 = 1'b1;
    mmio.mmio_uart_rx_ack   = 1'b0;
    mmio.mmio_uart_tx_req   = 1'b0;
    mmio.mmio_uart_data_out = 8'h00;
    tick(5);
    reset = 1'b0;

    // Idle after reset
    for (int c = 0; c < 200; c++) begin
      if (c == 0 || c == 199) begin
        check("rst_uart_tx", uart_tx, 1);
        check("rst_doorbell", mmio.mmio_uart_doorbell_flag, 0);
        check("rst_data_in", 32'(mmio.mmio_uart_data_in), 0);
        check("rst_tx_busy", mmio.tx_busy, 0);
        check("rst_overrun", rx_overrun, 0);
        check("rst_frame_err", rx_frame_err, 0);
      end
      tick(1);
    end

    // TX 0x55 then a back-to-back 0xC3 in the first idle cycle
    tx_exp.push_back(8'h55);
    start_tx(8'h55);
    check("tx_busy_rise", mmio.tx_busy, 1);
    check("tx_line_fall", uart_tx, 0);
    measure_busy(n);
    check("tx_busy_cycles", 32'(n), 100);
    tx_exp.push_back(8'hC3);
    start_tx(8'hC3);
    check("tx_b2b_busy", mmio.tx_busy, 1);
    measure_busy(n);
    check("tx_b2b_cycles", 32'(n), 100);
    tick(5);

    // RX 0xA5 then pop
    rx_exp.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    wait_doorbell();
    check("rx_head_a5", 32'(mmio.mmio_uart_data_in), 32'hA5);
    ack();
    check("rx_pop_doorbell", mmio.mmio_uart_doorbell_flag, 0);
    check("rx_pop_data_in", 32'(mmio.mmio_uart_data_in), 0);

    // Glitch: 3-cycle low pulse
    uart_rx = 1'b0;
    tick(3);
    uart_rx = 1'b1;
    tick(10 * DIV);
    check("glitch_doorbell", mmio.mmio_uart_doorbell_flag, 0);
    check("glitch_frame_err", rx_frame_err, 0);
    check("glitch_overrun", rx_overrun, 0);

    // Overrun: 17 frames without ack
    for (int b = 0; b <= 16; b++) begin
`ifdef UART_MMIO_BRIDGE_RX_FIFO_EN
      if (b < 16) rx_exp.push_back(8'(b));
`else
      if (b < 1) rx_exp.push_back(8'(b));
`endif
      send_frame(8'(b), 1'b1);
    end
    check("ovr_flag", rx_overrun, 1);
    check("ovr_head", 32'(mmio.mmio_uart_data_in), 0);
`ifdef UART_MMIO_BRIDGE_RX_FIFO_EN
    for (int k = 0; k < 16; k++) ack();
`else
    ack();
`endif
    check("ovr_drained_doorbell", mmio.mmio_uart_doorbell_flag, 0);
    check("ovr_drained_data_in", 32'(mmio.mmio_uart_data_in), 0);
    check("ovr_no_frame_err", rx_frame_err, 0);

    // Framing error: 0x3C with stop bit low
    send_frame(8'h3C, 1'b0);
    check("ferr_flag", rx_frame_err, 1);
    check("ferr_doorbell", mmio.mmio_uart_doorbell_flag, 0);

    // Reset mid-TX
    tx_mon_en = 1'b0;
    start_tx(8'h00);
    tick(30);
    check("midtx_line_low", uart_tx, 0);
    reset = 1'b1;
    #1;
    check("midtx_reset_line", uart_tx, 1);
    check("midtx_reset_busy", mmio.tx_busy, 0);
    check("midtx_reset_ferr", rx_frame_err, 0);
    check("midtx_reset_ovr", rx_overrun, 0);
    tick(3);
    reset = 1'b0;
    tick(20);
    check("post_reset_line", uart_tx, 1);
    check("post_reset_busy", mmio.tx_busy, 0);

    check("rx_queue_empty", 32'(rx_exp.size()), 0);
    check("tx_queue_empty", 32'(tx_exp.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
